addsub_pipe: RTL
================

// Module: addsub_pipe
// PURPOSE
//  Parametrised, pipelined add/subtract unit with a conditional-invert operand stage and NZCV flags.
//  Generalises the fixed 32-bit operand inverter into a WIDTH-wide, handshaked datapath block.
//  It sits between the ALU operand mux and the writeback/flag register.
//  Valid/ready on both sides; one op per cycle sustained; STAGES cycles of latency.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=2)
//  STAGES  2   pipeline depth: 1 = invert+add in one registered stage; 2 = invert reg, then add reg
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand/op presented
//  in_ready   out  1      unit accepts op this cycle (transfer = in_valid & in_ready)
//  op         in   2      00 ADD a+b; 01 SUB a-b; 10 NEG 0-b; 11 INV ~b
//  a          in   WIDTH  operand A (ignored for NEG/INV)
//  b          in   WIDTH  operand B (conditionally inverted)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts (transfer = out_valid & out_ready)
//  result     out  WIDTH  result
//  flag_n     out  1      result[WIDTH-1]
//  flag_z     out  1      result == 0
//  flag_c     out  1      adder carry-out (SUB/NEG: 1 = no borrow); 0 for INV
//  flag_v     out  1      signed overflow of A'+B'+cin; 0 for INV
// BEHAVIOUR
//  - Reset: all stage valids 0; out_valid=0, result=0, all flags=0; in_ready=1 from the first cycle after rst.
//  - Operand conditioning: b' = b ^ {WIDTH{inv}}, where inv = (op!=ADD); a' = (op[1]) ? 0 : a;
//    cin = (op==SUB || op==NEG). INV result = b' (adder bypassed).
//  - Sum is WIDTH+1 bits: {flag_c,result} = a' + b' + cin.
//    V = (a'[MSB]==b'[MSB]) & (result[MSB]!=a'[MSB]).
//  - Pipeline: each stage holds {valid, payload}.
//    A stage loads when it is empty or its contents are leaving this cycle.
//    in_ready = !s1_valid | s1_leaves (combinational from out_ready; no bubble when out_ready=1).
//  - Latency: accepted op appears on out_valid exactly STAGES cycles later when never stalled.
//    Throughput 1/cycle.
//  - Backpressure: while out_valid & !out_ready, result and flags hold stable. Upstream stages fill, then in_ready=0.
//    No op is dropped or duplicated.
//  - Simultaneous accept and drain in a full pipe: all stages shift and the new op enters.
//  - Reset mid-operation: all in-flight ops are discarded and outputs return to reset values in the same edge.
//    rst has priority over all handshakes.
//  - Wrap-around: ADD/SUB wrap modulo 2^WIDTH. Carry/overflow are reported only via flags.
//  - Payload registers load only on accept (no X propagation when in_valid=0).
// STRUCTURE
//  - Shared package alu_pkg: op encodings (OP_ADD/OP_SUB/OP_NEG/OP_INV as 2-bit localparams) and the
//    flag bit-index constants for the NZCV vector.
//  - One sub-module: cond_invert #(WIDTH) — combinational out = in ^ {WIDTH{ctrl}}, instantiated for b.
//  - Stage registers are generated from STAGES; adder is behavioural '+'.
// TESTING
//  1 ADD WIDTH=32: a=0x7FFFFFFF, b=1 -> result=0x80000000, N=1 Z=0 C=0 V=1, out_valid after 2 cycles.
//  2 SUB: a=5, b=5 -> result=0, Z=1 C=1 V=0.
//    a=0, b=1 -> result=0xFFFFFFFF, N=1 C=0 V=0.
//  3 NEG b=0x80000000 -> result=0x80000000, V=1. INV b=0x0000FFFF -> result=0xFFFF0000, C=0 V=0.
//  4 Stream 8 back-to-back ops with out_ready=1: 8 results in order on consecutive cycles, in_ready stays 1.
//  5 out_ready=0 for 5 cycles mid-stream: result held stable, in_ready drops after STAGES accepts.
//    Release: no loss, no duplicates, in order.
//  6 Assert rst with 2 ops in flight -> next cycle out_valid=0, result=0, flags=0, in_ready=1.
//    Neither op emerges. Repeat tests 1–5 with STAGES=1 (latency 1) and WIDTH=8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the add/subtract datapath: operation encodings and
// bit positions of the NZCV flag vector.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  localparam int FLAG_V    = 0;
  localparam int FLAG_C    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/cond_invert.sv
// Conditional bitwise inverter: passes the operand through, or inverts every
// bit when ctrl is set.
module cond_invert #(
  parameter int WIDTH = 32
) (
  input  logic             ctrl,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  assign out = in ^ {WIDTH{ctrl}};

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract/negate/invert unit with NZCV flags and valid/ready
// handshakes on both sides. STAGES=1 registers the result only; STAGES=2 adds an operand register.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  logic             inv;
  logic             cin;
  logic             byp;
  logic [WIDTH-1:0] a_cond;
  logic [WIDTH-1:0] b_cond;

  assign inv    = (op != OP_ADD);
  assign cin    = (op == OP_SUB) || (op == OP_NEG);
  assign byp    = (op == OP_INV);
  assign a_cond = op[1] ? '0 : a;

  cond_invert #(.WIDTH(WIDTH)) u_b_inv (
    .ctrl (inv),
    .in   (b),
    .out  (b_cond)
  );

  // The output stage can take new data when empty or when its content drains now.
  logic out_load;
  assign out_load = !out_valid || out_ready;

  logic             feed_valid;
  logic [WIDTH-1:0] feed_a;
  logic [WIDTH-1:0] feed_b;
  logic             feed_cin;
  logic             feed_byp;

  generate
    if (STAGES == 1) begin : g_one_stage
      assign in_ready   = out_load;
      assign feed_valid = in_valid;
      assign feed_a     = a_cond;
      assign feed_b     = b_cond;
      assign feed_cin   = cin;
      assign feed_byp   = byp;
    end else begin : g_two_stage
      logic             s1_valid;
      logic [WIDTH-1:0] s1_a;
      logic [WIDTH-1:0] s1_b;
      logic             s1_cin;
      logic             s1_byp;

      assign in_ready = !s1_valid || out_load;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_a     <= '0;
          s1_b     <= '0;
          s1_cin   <= 1'b0;
          s1_byp   <= 1'b0;
        end else if (in_ready) begin
          s1_valid <= in_valid;
          if (in_valid) begin
            s1_a   <= a_cond;
            s1_b   <= b_cond;
            s1_cin <= cin;
            s1_byp <= byp;
          end
        end
      end

      assign feed_valid = s1_valid;
      assign feed_a     = s1_a;
      assign feed_b     = s1_b;
      assign feed_cin   = s1_cin;
      assign feed_byp   = s1_byp;
    end
  endgenerate

  logic [WIDTH:0]         sum;
  logic [WIDTH-1:0]       calc_res;
  logic [NUM_FLAGS-1:0]   calc_flags;

  assign sum = {1'b0, feed_a} + {1'b0, feed_b} + {{WIDTH{1'b0}}, feed_cin};

  always_comb begin
    calc_res           = feed_byp ? feed_b : sum[WIDTH-1:0];
    calc_flags         = '0;
    calc_flags[FLAG_N] = calc_res[WIDTH-1];
    calc_flags[FLAG_Z] = (calc_res == '0);
    calc_flags[FLAG_C] = !feed_byp && sum[WIDTH];
    calc_flags[FLAG_V] = !feed_byp && (feed_a[WIDTH-1] == feed_b[WIDTH-1])
                         && (calc_res[WIDTH-1] != feed_a[WIDTH-1]);
  end

  logic [NUM_FLAGS-1:0] flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (out_load) begin
      out_valid <= feed_valid;
      if (feed_valid) begin
        result <= calc_res;
        flags  <= calc_flags;
      end
    end
  end

  assign flag_n = flags[FLAG_N];
  assign flag_z = flags[FLAG_Z];
  assign flag_c = flags[FLAG_C];
  assign flag_v = flags[FLAG_V];

endmodule
